// File: rtl/block_pe_elastic.sv
// Elastic processing element: N valid/ready inputs, operand crossbar, ALU with accumulate, output FIFO.
// Optional macro BLOCK_PE_SAT_EN: signed saturation for ADD/SUB/ACC plus a sat_flag output.
module block_pe_elastic #(
  parameter int DATA_W    = 32,
  parameter int NUM_IN    = 4,
  parameter int OUT_DEPTH = 2,
  parameter int SEL_W     = $clog2(NUM_IN + 2),
  parameter int CFG_W     = 4 + 2 * SEL_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     config_en,
  input  logic                     config_in,
  output logic                     config_out,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef BLOCK_PE_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_MUL  = 4'd7,
    OP_PASS = 4'd8,
    OP_ACC  = 4'd9,
    OP_MIN  = 4'd10,
    OP_MAX  = 4'd11
  } op_e;

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CFG_W-1:0]  cfg;
  op_e               op;
  logic [SEL_W-1:0]  sel_a, sel_b;
  logic [DATA_W-1:0] cfg_const;
  logic [DATA_W-1:0] fb_reg;
  logic [DATA_W-1:0] a_val, b_val, result;
  logic              a_ok, b_ok, uses_b, is_nop, fire, sat;
  logic [DATA_W-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, push, pop;

  assign op         = op_e'(cfg[3:0]);
  assign sel_a      = cfg[4 +: SEL_W];
  assign sel_b      = cfg[4 + SEL_W +: SEL_W];
  assign cfg_const  = cfg[CFG_W-1 -: DATA_W];
  assign config_out = cfg[0];

  // Operand crossbar; codes past the feedback slot read as zero and never wait on a valid.
  always_comb begin
    a_val = '0;
    b_val = '0;
    a_ok  = 1'b1;
    b_ok  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_a == SEL_W'(i)) begin
        a_val = in_data[i*DATA_W +: DATA_W];
        a_ok  = in_valid[i];
      end
      if (sel_b == SEL_W'(i)) begin
        b_val = in_data[i*DATA_W +: DATA_W];
        b_ok  = in_valid[i];
      end
    end
    if (sel_a == SEL_W'(NUM_IN)) a_val = cfg_const;
    else if (sel_a == SEL_W'(NUM_IN + 1)) a_val = fb_reg;
    if (sel_b == SEL_W'(NUM_IN)) b_val = cfg_const;
    else if (sel_b == SEL_W'(NUM_IN + 1)) b_val = fb_reg;
  end

  assign is_nop = (cfg[3:2] == 2'b11);
  assign uses_b = !is_nop && (op != OP_PASS) && (op != OP_ACC);

  always_comb begin
    result = '0;
    sat    = 1'b0;
    case (op)
      OP_ADD:  result = a_val + b_val;
      OP_SUB:  result = a_val - b_val;
      OP_AND:  result = a_val & b_val;
      OP_OR:   result = a_val | b_val;
      OP_XOR:  result = a_val ^ b_val;
      OP_SHL:  result = a_val << b_val[4:0];
      OP_SHR:  result = a_val >> b_val[4:0];
      OP_MUL:  result = a_val * b_val;
      OP_PASS: result = a_val;
      OP_ACC:  result = fb_reg + a_val;
      OP_MIN:  result = (a_val < b_val) ? a_val : b_val;
      OP_MAX:  result = (a_val > b_val) ? a_val : b_val;
      default: result = '0;
    endcase
`ifdef BLOCK_PE_SAT_EN
    // Signed overflow: the sign of the raw result disagrees with what the operand signs allow.
    if (op == OP_ADD && a_val[DATA_W-1] == b_val[DATA_W-1] && result[DATA_W-1] != a_val[DATA_W-1]) begin
      sat    = 1'b1;
      result = a_val[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else if (op == OP_SUB && a_val[DATA_W-1] != b_val[DATA_W-1] && result[DATA_W-1] != a_val[DATA_W-1]) begin
      sat    = 1'b1;
      result = a_val[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else if (op == OP_ACC && fb_reg[DATA_W-1] == a_val[DATA_W-1] && result[DATA_W-1] != fb_reg[DATA_W-1]) begin
      sat    = 1'b1;
      result = fb_reg[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`endif
  end

  assign full      = (count == CNT_W'(OUT_DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign fire      = !reset && !config_en && !is_nop && (!full || out_ready) && a_ok && (!uses_b || b_ok);
  assign push      = fire;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++)
      in_ready[i] = fire && ((sel_a == SEL_W'(i)) || (uses_b && (sel_b == SEL_W'(i))));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg    <= '0;
      fb_reg <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (config_en) cfg <= {config_in, cfg[CFG_W-1:1]};
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        fb_reg <= result;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

`ifdef BLOCK_PE_SAT_EN
  always_ff @(posedge clk) begin
    if (reset) sat_flag <= 1'b0;
    else sat_flag <= push && sat;
  end
`endif

endmodule

// File: tb/tb_block_pe_elastic.sv
// Directed bench for block_pe_elastic (DATA_W=8, NUM_IN=4, OUT_DEPTH=2); honours BLOCK_PE_SAT_EN.
module tb_block_pe_elastic;

  localparam int DW    = 8;
  localparam int NI    = 4;
  localparam int SW    = 3;
  localparam int CW    = 4 + 2 * SW + DW;

`ifdef BLOCK_PE_SAT_EN
  localparam logic [7:0] ADD_SAT_EXP = 8'h7F;
  localparam logic [7:0] SUB_SAT_EXP = 8'h80;
  localparam logic       SAT_ON      = 1'b1;
`else
  localparam logic [7:0] ADD_SAT_EXP = 8'hC8;
  localparam logic [7:0] SUB_SAT_EXP = 8'h7F;
  localparam logic       SAT_ON      = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          config_en = 1'b0;
  logic          config_in = 1'b0;
  logic          config_out;
  logic [NI*DW-1:0] in_data = '0;
  logic [NI-1:0] in_valid = '0;
  logic [NI-1:0] in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
`ifdef BLOCK_PE_SAT_EN
  logic          sat_flag;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  block_pe_elastic #(.DATA_W(DW), .NUM_IN(NI), .OUT_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .config_en(config_en), .config_in(config_in),
    .config_out(config_out), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef BLOCK_PE_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [7:0]  cst;
    logic [31:0] din;
    logic [3:0]  vld;
    logic [3:0]  exp_rdy;
    logic        exp_vld;
    logic [7:0]  exp_data;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [19];
  logic [CW-1:0] cfg_word;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    config_en = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_cfg(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] c);
    cfg_word = {c, sb, sa, op};
    for (int k = 0; k < CW; k++) begin
      config_en = 1'b1;
      config_in = cfg_word[k];
      @(negedge clk);
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    in_data   = v.din;
    in_valid  = v.vld;
    out_ready = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"add",        4'd0,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd7, 8'd5},        4'b0011, 4'b0011, 1'b1, 8'd12,       1'b0};
    vecs[1]  = '{"sub_const",  4'd1,  3'd4, 3'd2, 8'd100, {8'd0, 8'd30, 8'd0, 8'd0},       4'b0100, 4'b0100, 1'b1, 8'd70,       1'b0};
    vecs[2]  = '{"sub_nofire", 4'd1,  3'd4, 3'd2, 8'd100, {8'd0, 8'd0, 8'd0, 8'd9},        4'b0001, 4'b0000, 1'b0, 8'd0,        1'b0};
    vecs[3]  = '{"and",        4'd2,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'h3C, 8'hF0},      4'b0011, 4'b0011, 1'b1, 8'h30,       1'b0};
    vecs[4]  = '{"or",         4'd3,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'h3C, 8'hF0},      4'b0011, 4'b0011, 1'b1, 8'hFC,       1'b0};
    vecs[5]  = '{"xor",        4'd4,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'h3C, 8'hF0},      4'b0011, 4'b0011, 1'b1, 8'hCC,       1'b0};
    vecs[6]  = '{"shl",        4'd5,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd4, 8'h03},       4'b0011, 4'b0011, 1'b1, 8'h30,       1'b0};
    vecs[7]  = '{"shl_wide",   4'd5,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd9, 8'h03},       4'b0011, 4'b0011, 1'b1, 8'h00,       1'b0};
    vecs[8]  = '{"shr",        4'd6,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd3, 8'h80},       4'b0011, 4'b0011, 1'b1, 8'h10,       1'b0};
    vecs[9]  = '{"mul",        4'd7,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd13, 8'd20},      4'b0011, 4'b0011, 1'b1, 8'd4,        1'b0};
    vecs[10] = '{"pass_a",     4'd8,  3'd3, 3'd0, 8'd0,   {8'h5A, 8'd0, 8'd0, 8'h77},      4'b1001, 4'b1000, 1'b1, 8'h5A,       1'b0};
    vecs[11] = '{"min",        4'd10, 3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd7, 8'd200},      4'b0011, 4'b0011, 1'b1, 8'd7,        1'b0};
    vecs[12] = '{"max",        4'd11, 3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd7, 8'd200},      4'b0011, 4'b0011, 1'b1, 8'd200,      1'b0};
    vecs[13] = '{"same_chan",  4'd0,  3'd1, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd9, 8'd0},        4'b0010, 4'b0010, 1'b1, 8'd18,       1'b0};
    vecs[14] = '{"zero_code",  4'd0,  3'd6, 3'd0, 8'd0,   {8'd0, 8'd0, 8'd0, 8'd11},       4'b0001, 4'b0001, 1'b1, 8'd11,       1'b0};
    vecs[15] = '{"nop",        4'd12, 3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd7, 8'd5},        4'b0011, 4'b0000, 1'b0, 8'd0,        1'b0};
    vecs[16] = '{"add_sat",    4'd0,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'd100, 8'd100},    4'b0011, 4'b0011, 1'b1, ADD_SAT_EXP, SAT_ON};
    vecs[17] = '{"sub_sat",    4'd1,  3'd0, 3'd1, 8'd0,   {8'd0, 8'd0, 8'h01, 8'h80},      4'b0011, 4'b0011, 1'b1, SUB_SAT_EXP, SAT_ON};
    vecs[18] = '{"const_fb",   4'd0,  3'd5, 3'd4, 8'd3,   {8'd0, 8'd0, 8'd0, 8'd0},        4'b0000, 4'b0000, 1'b1, 8'd3,        1'b0};

    @(negedge clk);
    do_reset();
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_config_out", 32'(config_out), 32'd0);
`ifdef BLOCK_PE_SAT_EN
    checkOutput("reset_sat_flag", 32'(sat_flag), 32'd0);
`endif
    @(negedge clk);

    // Single-shot vectors: fresh reset, configure, one offer, check the handshake then the result.
    for (int n = 0; n < 19; n++) begin
      do_reset();
      load_cfg(vecs[n].op, vecs[n].sa, vecs[n].sb, vecs[n].cst);
      applyStimulus(vecs[n]);
      #1;
      checkOutput({vecs[n].name, "_in_ready"}, 32'(in_ready), 32'(vecs[n].exp_rdy));
      @(negedge clk);
      in_valid = '0;
      #1;
      checkOutput({vecs[n].name, "_out_valid"}, 32'(out_valid), 32'(vecs[n].exp_vld));
      if (vecs[n].exp_vld) checkOutput({vecs[n].name, "_out_data"}, 32'(out_data), 32'(vecs[n].exp_data));
`ifdef BLOCK_PE_SAT_EN
      checkOutput({vecs[n].name, "_sat_flag"}, 32'(sat_flag), 32'(vecs[n].exp_sat));
      @(negedge clk);
      #1;
      checkOutput({vecs[n].name, "_sat_clear"}, 32'(sat_flag), 32'd0);
`endif
      @(negedge clk);
    end

    // Config readback: the loaded word leaves config_out LSB-first, nothing fires meanwhile.
    do_reset();
    load_cfg(4'd0, 3'd0, 3'd1, 8'hA5);
    begin
      logic [CW-1:0] prev;
      prev = cfg_word;
      in_data  = {8'd0, 8'd0, 8'd7, 8'd5};
      in_valid = 4'b0011;
      out_ready = 1'b1;
      for (int k = 0; k < CW; k++) begin
        config_en = 1'b1;
        config_in = 1'($urandom_range(1));
        #1;
        checkOutput($sformatf("readback_bit%0d", k), 32'(config_out), 32'(prev[k]));
        checkOutput($sformatf("readback_ready%0d", k), 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      in_valid  = '0;
      config_en = 1'b0;
      #1;
      checkOutput("readback_no_fire", 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    // Accumulate back-to-back: results stream out one per cycle.
    do_reset();
    load_cfg(4'd9, 3'd0, 3'd0, 8'd0);
    out_ready = 1'b1;
    begin
      logic [7:0] acc_model;
      logic [7:0] prev_exp;
      acc_model = 8'd0;
      prev_exp  = 8'd0;
      for (int k = 0; k < 4; k++) begin
        in_data  = {24'd0, 8'(k + 1)};
        in_valid = 4'b0001;
        #1;
        checkOutput($sformatf("acc_ready%0d", k), 32'(in_ready), 32'd1);
        if (k > 0) begin
          checkOutput($sformatf("acc_valid%0d", k - 1), 32'(out_valid), 32'd1);
          checkOutput($sformatf("acc_data%0d", k - 1), 32'(out_data), 32'(prev_exp));
        end
        acc_model = acc_model + 8'(k + 1);
        prev_exp  = acc_model;
        @(negedge clk);
      end
      in_valid = '0;
      #1;
      checkOutput("acc_data3", 32'(out_data), 32'd10);
      @(negedge clk);
    end

    // Back-pressure: two tokens fill the FIFO, third waits until the first pop.
    do_reset();
    load_cfg(4'd8, 3'd0, 3'd0, 8'd0);
    in_data = {24'd0, 8'h11}; in_valid = 4'b0001;
    #1; checkOutput("bp_tok0_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_data = {24'd0, 8'h22};
    #1; checkOutput("bp_tok1_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_head_early", 32'(out_data), 32'h11);
    @(negedge clk);
    in_data = {24'd0, 8'h33};
    #1; checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    #1; checkOutput("bp_full_pop_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_pop0", 32'(out_data), 32'h11);
    @(negedge clk);
    in_valid = '0;
    #1; checkOutput("bp_pop1", 32'(out_data), 32'h22);
    @(negedge clk);
    #1; checkOutput("bp_pop2", 32'(out_data), 32'h33);
    checkOutput("bp_pop2_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #1; checkOutput("bp_empty", 32'(out_valid), 32'd0);
    @(negedge clk);

    // config_en blocks firing but the FIFO keeps draining.
    do_reset();
    load_cfg(4'd8, 3'd0, 3'd0, 8'd0);
    in_data = {24'd0, 8'h44}; in_valid = 4'b0001;
    @(negedge clk);
    in_data = {24'd0, 8'h55};
    config_en = 1'b1; config_in = 1'b0; out_ready = 1'b1;
    #1; checkOutput("cfgen_ready", 32'(in_ready), 32'd0);
    checkOutput("cfgen_head", 32'(out_data), 32'h44);
    @(negedge clk);
    config_en = 1'b0; in_valid = '0;
    #1; checkOutput("cfgen_drained", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Reset mid-operation drops the FIFO and suppresses in_ready in the reset cycle.
    do_reset();
    load_cfg(4'd8, 3'd0, 3'd0, 8'd0);
    in_data = {24'd0, 8'h66}; in_valid = 4'b0001;
    @(negedge clk);
    reset = 1'b1;
    #1; checkOutput("midreset_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = '0;
    #1; checkOutput("midreset_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_cfgout", 32'(config_out), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
